// File: rtl/desc_word_streamer_if.sv
// Pixel-in / word-out handshake bundle for the descriptor word streamer.
// The master modport is the streamer; the slave modport is its environment
// (pixel source and NCC descriptor receiver).
interface desc_word_streamer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic [31:0] desc_data_in;
  logic        desc_data_ready;
  logic        desc_word_taken;
  logic [3:0]  desc_row;
  logic [1:0]  desc_col;

  modport master (
    input  pix_valid,
    input  pix_data,
    input  desc_word_taken,
    output pix_ready,
    output desc_data_in,
    output desc_data_ready,
    output desc_row,
    output desc_col
  );

  modport slave (
    output pix_valid,
    output pix_data,
    output desc_word_taken,
    input  pix_ready,
    input  desc_data_in,
    input  desc_data_ready,
    input  desc_row,
    input  desc_col
  );
endinterface

// File: rtl/desc_word_streamer.sv
// Descriptor word streamer: packs four consecutive 8-bit pixels into one
// 32-bit word (first pixel in [31:24]) and queues words in a small FIFO
// for the NCC descriptor loader. One transfer covers NUM_PIXELS pixels.
module desc_word_streamer #(
  parameter int NUM_PIXELS = 256,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic desc_done,
  output logic err,
  desc_word_streamer_if.master strm
);

  localparam int NW = NUM_PIXELS / 4;
  localparam int PW = $clog2(NUM_PIXELS + 1);
  // Word index needs at least 6 bits so row (bits 5:2) and col (1:0) exist.
  localparam int IW = ($clog2(NW) < 6) ? 6 : $clog2(NW);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PW-1:0] PIX_LIMIT = PW'(NUM_PIXELS);
  localparam logic [IW-1:0] LAST_WORD = IW'(NW - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_SLOT = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [1:0]      byte_cnt_q;
  logic [23:0]     asm_q;        // first three bytes of the word being built
  logic [PW-1:0]   pix_cnt_q;
  logic [IW-1:0]   word_idx_q;   // index of the current FIFO head word
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic [31:0]     mem_q [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic pix_ready_int;
  logic accept;
  logic push;
  logic pop;
  logic last_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + AW'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  // Fullness uses the pre-pop count: a pop does not make room for a push
  // in the same cycle.
  assign fifo_full  = (count_q == FIFO_FULL);

  // Only the byte that completes a word needs FIFO room; bytes 0..2 land in
  // the assembly register and can always be taken.
  assign pix_ready_int = (state_q == S_PACK) && (pix_cnt_q != PIX_LIMIT) &&
                         !((byte_cnt_q == 2'd3) && fifo_full);

  assign accept   = strm.pix_valid && pix_ready_int;
  assign push     = accept && (byte_cnt_q == 2'd3);
  assign pop      = (state_q == S_PACK) && strm.desc_word_taken && !fifo_empty;
  assign last_pop = pop && (word_idx_q == LAST_WORD);

  // Control FSM, byte assembly, FIFO pointers/count and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      pix_cnt_q  <= '0;
      word_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
            pix_cnt_q  <= '0;
            word_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            state_q    <= S_PACK;
          end
        end
        S_PACK: begin
          if (accept) begin
            pix_cnt_q  <= pix_cnt_q + PW'(1);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    asm_q[23:16] <= strm.pix_data;
              2'd1:    asm_q[15:8]  <= strm.pix_data;
              2'd2:    asm_q[7:0]   <= strm.pix_data;
              default: ;  // byte 3 goes straight into the FIFO entry
            endcase
          end
          if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
          end
          if (pop) begin
            rd_ptr_q   <= ptr_inc(rd_ptr_q);
            word_idx_q <= word_idx_q + IW'(1);
          end
          if (push && !pop) begin
            count_q <= count_q + CW'(1);
          end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
          end
          if (strm.desc_word_taken && fifo_empty) begin
            err_q <= 1'b1;
          end
          if (last_pop) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage: the completing byte is merged with the assembled bytes on push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {asm_q, strm.pix_data};
    end
  end

  assign busy      = (state_q == S_PACK);
  assign desc_done = (state_q == S_DONE);
  assign err       = err_q;

  assign strm.pix_ready       = pix_ready_int;
  assign strm.desc_data_ready = !fifo_empty;
  // Empty FIFO presents zero so the head word has a defined reset value.
  assign strm.desc_data_in    = fifo_empty ? 32'h0000_0000 : mem_q[rd_ptr_q];
  assign strm.desc_row        = word_idx_q[5:2];
  assign strm.desc_col        = word_idx_q[1:0];

endmodule

// File: tb/tb_desc_word_streamer.sv
// Self-checking bench for desc_word_streamer. Expected words are derived
// from the list of offered pixels (word k = pixels 4k..4k+3, MSB first);
// the bench drives at the falling edge and samples before driving.
module tb_desc_word_streamer;

  localparam int NP = 256;
  localparam int NW = NP / 4;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic desc_done;
  logic err;

  desc_word_streamer_if bus ();

  desc_word_streamer #(
    .NUM_PIXELS(NP),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .desc_done(desc_done),
    .err      (err),
    .strm     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  pix_src[$];
  logic [31:0] words_seen[$];
  int n_acc = 0;
  int n_pop = 0;
  bit just_last = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    if (4 * k + 3 >= pix_src.size()) return 32'hDEAD_BEEF;
    return {pix_src[4*k], pix_src[4*k+1], pix_src[4*k+2], pix_src[4*k+3]};
  endfunction

  task automatic fill_pixels(input bit ramp);
    pix_src.delete();
    for (int i = 0; i < NP; i++) begin
      pix_src.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    end
  endtask

  // One clock cycle: called just after a falling edge, returns after the next one.
  task automatic step(input bit v, input bit t, input bit st);
    bit acc;
    bit pop;
    start               = st;
    bus.pix_valid       = v;
    bus.pix_data        = (n_acc < pix_src.size()) ? pix_src[n_acc] : 8'hEE;
    bus.desc_word_taken = t;
    acc = bus.pix_valid && bus.pix_ready;
    pop = t && bus.desc_data_ready;
    if (pop) begin
      check("word", bus.desc_data_in, exp_word(n_pop));
      check("row", {28'b0, bus.desc_row}, 32'((n_pop / 4) % 16));
      check("col", {30'b0, bus.desc_col}, 32'(n_pop % 4));
      words_seen.push_back(bus.desc_data_in);
    end
    @(posedge clk);
    if (acc) n_acc++;
    if (pop) n_pop++;
    just_last = pop && (n_pop == NW);
    @(negedge clk);
  endtask

  task automatic do_start(input bit ramp);
    fill_pixels(ramp);
    n_acc = 0;
    n_pop = 0;
    words_seen.delete();
    step(1'b0, 1'b0, 1'b1);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("pix_ready_after_start", {31'b0, bus.pix_ready}, 32'd1);
    check("err_after_start", {31'b0, err}, 32'd0);
    check("empty_after_start", {31'b0, bus.desc_data_ready}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_pix_ready"}, {31'b0, bus.pix_ready}, 32'd0);
    check({tag, "_data_ready"}, {31'b0, bus.desc_data_ready}, 32'd0);
    check({tag, "_done"}, {31'b0, desc_done}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_data"}, bus.desc_data_in, 32'd0);
    check({tag, "_row"}, {28'b0, bus.desc_row}, 32'd0);
    check({tag, "_col"}, {30'b0, bus.desc_col}, 32'd0);
  endtask

  // Streams until desc_done; ncc=1 takes every other cycle while ready,
  // otherwise takes with probability tpct while ready.
  task automatic run_stream(input int vpct, input int tpct, input bit ncc,
                            input int mid_start, input bit start_in_done,
                            input bit exp_err);
    int cyc = 0;
    bit prev_t = 0;
    bit v;
    bit t;
    bit fin = 0;
    while (!fin && cyc < 6000) begin
      v = ($urandom_range(0, 99) < vpct);
      if (ncc) t = bus.desc_data_ready && !prev_t;
      else     t = bus.desc_data_ready && ($urandom_range(0, 99) < tpct);
      prev_t = t;
      step(v, t, cyc == mid_start);
      cyc++;
      check("done_timing", {31'b0, desc_done}, {31'b0, just_last});
      if (desc_done) begin
        check("busy_in_done", {31'b0, busy}, 32'd0);
        step(1'b0, 1'b0, start_in_done);
        check("done_single", {31'b0, desc_done}, 32'd0);
        check("busy_after_done", {31'b0, busy}, 32'd0);
        check("idle_pix_ready", {31'b0, bus.pix_ready}, 32'd0);
        fin = 1;
      end else begin
        check("busy_in_pack", {31'b0, busy}, 32'd1);
      end
    end
    start = 1'b0;
    check("stream_finished", {31'b0, fin}, 32'd1);
    check("pixels_accepted", n_acc, NP);
    check("words_popped", n_pop, NW);
    check("err_at_end", {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bit prev_t;
    bit t;
    rst = 1'b1;
    start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = 8'h00;
    bus.desc_word_taken = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full stream, ramp pixels, NCC-style receiver.
    do_start(1'b1);
    run_stream(100, 0, 1'b1, -1, 1'b0, 1'b0);
    check("first_word", words_seen[0], 32'h0001_0203);
    check("word5", words_seen[5], 32'h1415_1617);
    check("last_word", words_seen[NW-1], 32'hFCFD_FEFF);

    // Backpressure: receiver never takes.
    do_start(1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
    check("bp_accepted", n_acc, 11);
    check("bp_pix_ready", {31'b0, bus.pix_ready}, 32'd0);
    check("bp_data_ready", {31'b0, bus.desc_data_ready}, 32'd1);
    check("bp_head", bus.desc_data_in, 32'h0001_0203);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check("bp_head_stable", bus.desc_data_in, 32'h0001_0203);
    check("bp_still_11", n_acc, 11);
    run_stream(100, 100, 1'b0, -1, 1'b0, 1'b0);

    // Protocol error: take with an empty FIFO.
    do_start(1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("err_set", {31'b0, err}, 32'd1);
    run_stream(100, 0, 1'b1, -1, 1'b0, 1'b1);

    // Start while busy (mid-transfer and in DONE); start also clears err.
    do_start(1'b0);
    run_stream(80, 0, 1'b1, 50, 1'b1, 1'b0);

    // Reset after 37 pixels with a partial word pending.
    do_start(1'b0);
    guard = 0;
    prev_t = 0;
    while (n_acc < 37 && guard < 500) begin
      t = bus.desc_data_ready && !prev_t;
      prev_t = t;
      step(1'b1, t, 1'b0);
      guard++;
    end
    check("pre_reset_count", n_acc, 37);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(1'b0);
    run_stream(60, 50, 1'b0, -1, 1'b0, 1'b0);
    check("after_reset_first", words_seen[0],
          {pix_src[0], pix_src[1], pix_src[2], pix_src[3]});

    // Random gaps, including fill-to-full followed by simultaneous push/pop.
    do_start(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    run_stream(90, 70, 1'b0, -1, 1'b0, 1'b0);
    do_start(1'b0);
    run_stream(40, 90, 1'b0, -1, 1'b0, 1'b0);
    do_start(1'b0);
    run_stream(95, 30, 1'b0, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
